// File: rtl/video_timing_pkg.sv
// Shared video timing definitions: 1080p60 constants, pixel type and FSM states,
// plus helpers that derive line/frame totals and sync start points from porches.
package video_timing_pkg;

  localparam int unsigned H_ACTIVE_1080P = 1920;
  localparam int unsigned H_FP_1080P     = 88;
  localparam int unsigned H_SYNC_1080P   = 44;
  localparam int unsigned H_BP_1080P     = 148;
  localparam int unsigned V_ACTIVE_1080P = 1080;
  localparam int unsigned V_FP_1080P     = 4;
  localparam int unsigned V_SYNC_1080P   = 5;
  localparam int unsigned V_BP_1080P     = 36;

  typedef logic [23:0] rgb888_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ftg_state_t;

  function automatic int unsigned timing_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned sync_start(input int unsigned active,
                                             input int unsigned fp);
    return active + fp;
  endfunction

endpackage

// File: rtl/vid_delay_line.sv
// Fixed-depth shift register that delays the {de, hs, vs} control bundle so it
// lines up with pixels returned by the fetch stage.
module vid_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // shift the control bundle one stage per clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/frame_timing_gen.sv
// Frame raster timing generator: one frame per trigger, fetch-side decode and
// pixel re-alignment toward the HDMI transmitter. Optional status block: FRAME_TIMING_GEN_STATUS_EN.
module frame_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_1080P,
  parameter int unsigned H_FP     = H_FP_1080P,
  parameter int unsigned H_SYNC   = H_SYNC_1080P,
  parameter int unsigned H_BP     = H_BP_1080P,
  parameter int unsigned V_ACTIVE = V_ACTIVE_1080P,
  parameter int unsigned V_FP     = V_FP_1080P,
  parameter int unsigned V_SYNC   = V_SYNC_1080P,
  parameter int unsigned V_BP     = V_BP_1080P,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned DATA_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_trig,
  output logic        frame_busy,
  output logic        h_sync_out,
  output logic        v_sync_out,
  output logic        de_out,
  input  logic [23:0] pix_data_in,
  output logic        vid_hs,
  output logic        vid_vs,
  output logic        vid_de,
  output logic [23:0] vid_data
`ifdef FRAME_TIMING_GEN_STATUS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic        trig_drop,
  input  logic        status_clr
`endif
);

  localparam int unsigned H_TOTAL  = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_START = sync_start(H_ACTIVE, H_FP);
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = sync_start(V_ACTIVE, V_FP);
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  ftg_state_t    state_r;
  ftg_state_t    state_nxt;
  logic [HW-1:0] h_cnt_r;
  logic [HW-1:0] h_cnt_nxt;
  logic [VW-1:0] v_cnt_r;
  logic [VW-1:0] v_cnt_nxt;
  logic          busy_nxt;
  logic          h_wrap_s;
  logic          last_cycle_s;
  logic          run_s;
  logic          de_s;
  logic          hs_s;
  logic          vs_s;
  logic [2:0]    dly_s;
  rgb888_t       pix_gated_s;

  assign run_s        = (state_r == ST_RUN);
  assign h_wrap_s     = (h_cnt_r == HW'(H_TOTAL - 1));
  assign last_cycle_s = h_wrap_s && (v_cnt_r == VW'(V_TOTAL - 1));

  // state, raster counters and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      h_cnt_r    <= {HW{1'b0}};
      v_cnt_r    <= {VW{1'b0}};
      frame_busy <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      h_cnt_r    <= h_cnt_nxt;
      v_cnt_r    <= v_cnt_nxt;
      frame_busy <= busy_nxt;
    end
  end

  // next-state, counter advance and busy decision
  always_comb begin
    state_nxt = state_r;
    h_cnt_nxt = h_cnt_r;
    v_cnt_nxt = v_cnt_r;
    busy_nxt  = frame_busy;
    case (state_r)
      ST_IDLE: begin
        h_cnt_nxt = {HW{1'b0}};
        v_cnt_nxt = {VW{1'b0}};
        if (frame_trig) begin
          state_nxt = ST_RUN;
          busy_nxt  = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
        end
      end
      ST_RUN: begin
        if (last_cycle_s) begin
          // a trigger in the very last cycle chains the next frame seamlessly
          h_cnt_nxt = {HW{1'b0}};
          v_cnt_nxt = {VW{1'b0}};
          if (frame_trig) begin
            state_nxt = ST_RUN;
            busy_nxt  = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
          end
        end else if (h_wrap_s) begin
          h_cnt_nxt = {HW{1'b0}};
          v_cnt_nxt = v_cnt_r + VW'(1);
          busy_nxt  = 1'b1;
        end else begin
          h_cnt_nxt = h_cnt_r + HW'(1);
          busy_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        h_cnt_nxt = {HW{1'b0}};
        v_cnt_nxt = {VW{1'b0}};
        busy_nxt  = 1'b0;
      end
    endcase
  end

  assign de_s = run_s && (h_cnt_r < HW'(H_ACTIVE)) && (v_cnt_r < VW'(V_ACTIVE));
  assign hs_s = run_s && (h_cnt_r >= HW'(HS_START)) && (h_cnt_r < HW'(HS_END));
  assign vs_s = run_s && (v_cnt_r >= VW'(VS_START)) && (v_cnt_r < VW'(VS_END));

  // fetch-side timing outputs, one cycle behind the counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_out     <= 1'b0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
    end else begin
      de_out     <= de_s;
      h_sync_out <= hs_s;
      v_sync_out <= vs_s;
    end
  end

  vid_delay_line #(
    .DEPTH(DATA_LAT),
    .WIDTH(3)
  ) u_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({de_out, h_sync_out, v_sync_out}),
    .dout (dly_s)
  );

  assign pix_gated_s = dly_s[2] ? pix_data_in : 24'h000000;

  // transmitter stage: polarity applied, pixel data blanked outside active video
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_de   <= 1'b0;
      vid_hs   <= ~HS_POL;
      vid_vs   <= ~VS_POL;
      vid_data <= 24'h000000;
    end else begin
      vid_de   <= dly_s[2];
      vid_hs   <= dly_s[1] ^ ~HS_POL;
      vid_vs   <= dly_s[0] ^ ~VS_POL;
      vid_data <= pix_gated_s;
    end
  end

`ifdef FRAME_TIMING_GEN_STATUS_EN
  logic frame_end_s;
  logic drop_s;

  assign frame_end_s = run_s && last_cycle_s;
  assign drop_s      = run_s && frame_trig && !last_cycle_s;

  // frame counter and sticky dropped-trigger flag; a fresh drop beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 16'h0000;
      trig_drop <= 1'b0;
    end else begin
      if (status_clr) begin
        frame_cnt <= 16'h0000;
      end else if (frame_end_s) begin
        frame_cnt <= frame_cnt + 16'h0001;
      end else begin
        frame_cnt <= frame_cnt;
      end
      if (drop_s) begin
        trig_drop <= 1'b1;
      end else if (status_clr) begin
        trig_drop <= 1'b0;
      end else begin
        trig_drop <= trig_drop;
      end
    end
  end
`endif

endmodule

// File: tb/tb_frame_timing_gen.sv
// Directed bench for frame_timing_gen on a 14x7 raster; a second instance
// checks inverted sync polarity. Status checks need FRAME_TIMING_GEN_STATUS_EN.
module tb_frame_timing_gen;

  localparam int FT = 98;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_trig = 1'b0;
  logic [23:0] pix_data_in = 24'h000000;
  logic        frame_busy, h_sync_out, v_sync_out, de_out, vid_hs, vid_vs, vid_de;
  logic [23:0] vid_data;
  logic        p_frame_busy, p_h_sync_out, p_v_sync_out, p_de_out, p_vid_hs, p_vid_vs, p_vid_de;
  logic [23:0] p_vid_data;
`ifdef FRAME_TIMING_GEN_STATUS_EN
  logic        status_clr = 1'b0;
  logic [15:0] frame_cnt, p_frame_cnt;
  logic        trig_drop, p_trig_drop;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int pix_idx = 0;
  logic prev_de = 1'b0;
  int r_f_err, r_v_err, r_p_err, r_busy_hi, r_de_rises, r_hs_rises, r_vs_hi, r_fifth;

  always #5 clk = ~clk;

  frame_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .DATA_LAT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_trig(frame_trig), .frame_busy(frame_busy),
    .h_sync_out(h_sync_out), .v_sync_out(v_sync_out), .de_out(de_out),
    .pix_data_in(pix_data_in), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
    .vid_data(vid_data)
`ifdef FRAME_TIMING_GEN_STATUS_EN
    , .frame_cnt(frame_cnt), .trig_drop(trig_drop), .status_clr(status_clr)
`endif
  );

  frame_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .DATA_LAT(1)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .frame_trig(frame_trig), .frame_busy(p_frame_busy),
    .h_sync_out(p_h_sync_out), .v_sync_out(p_v_sync_out), .de_out(p_de_out),
    .pix_data_in(pix_data_in), .vid_hs(p_vid_hs), .vid_vs(p_vid_vs), .vid_de(p_vid_de),
    .vid_data(p_vid_data)
`ifdef FRAME_TIMING_GEN_STATUS_EN
    , .frame_cnt(p_frame_cnt), .trig_drop(p_trig_drop), .status_clr(status_clr)
`endif
  );

  // Expected {h[3:0], de, hs, vs} at sample n after the triggering edge.
  function automatic logic [6:0] exp_at(input int n, input bit two);
    int m, c, h, v;
    logic d, hs, vs;
    m = n;
    if (two && m > FT) m = m - FT;
    if (m < 1 || m > FT) return 7'd0;
    c  = m - 1;
    h  = c % 14;
    v  = c / 14;
    d  = (h < 8) && (v < 4);
    hs = (h == 10) || (h == 11);
    vs = (v == 5);
    return {h[3:0], d, hs, vs};
  endfunction

  // One clock; also models the fetch stage returning pixel index one cycle after de_out.
  task automatic step();
    @(posedge clk);
    #1;
    if (prev_de) begin
      pix_data_in = 24'(pix_idx);
      pix_idx++;
    end else begin
      pix_data_in = 24'hA5A5A5;
      pix_idx = 0;
    end
    prev_de = de_out;
  endtask

  task automatic play(input int len, input int t_a, input int t_b);
    logic [6:0] e, ev;
    logic [23:0] vdata;
    logic pde, phs;
    bit two;
    two = (t_b == FT - 1);
    r_f_err = 0; r_v_err = 0; r_p_err = 0; r_busy_hi = 0;
    r_de_rises = 0; r_hs_rises = 0; r_vs_hi = 0; r_fifth = -1;
    pde = 1'b0; phs = 1'b0;
    frame_trig = 1'b1;
    step();
    frame_trig = 1'b0;
    for (int n = 0; n < len; n++) begin
      e  = exp_at(n, two);
      ev = exp_at(n - 2, two);
      vdata = ev[2] ? {20'h00000, ev[6:3]} : 24'h000000;
      if ({de_out, h_sync_out, v_sync_out} !== e[2:0]) r_f_err++;
      if ({vid_de, vid_hs, vid_vs} !== ev[2:0] || vid_data !== vdata) r_v_err++;
      if ({p_vid_de, p_vid_hs, p_vid_vs} !== {ev[2], ~ev[1], ~ev[0]} || p_vid_data !== vdata ||
          {p_de_out, p_h_sync_out, p_v_sync_out} !== e[2:0] || p_frame_busy !== frame_busy) r_p_err++;
      if (frame_busy === 1'b1) r_busy_hi++;
      if (de_out === 1'b1 && !pde) begin
        r_de_rises++;
        if (r_de_rises == 5) r_fifth = n;
      end
      if (h_sync_out === 1'b1 && !phs) r_hs_rises++;
      if (v_sync_out === 1'b1) r_vs_hi++;
      pde = de_out;
      phs = h_sync_out;
      if (n == t_a || n == t_b) frame_trig = 1'b1;
      step();
      frame_trig = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (frame_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b want=0", frame_busy); end
    n_cmp++; if ({de_out, h_sync_out, v_sync_out} !== 3'b000) begin n_bad++; $display("FAIL rst_fetch got=%b want=000", {de_out, h_sync_out, v_sync_out}); end
    n_cmp++; if ({vid_de, vid_hs, vid_vs} !== 3'b000) begin n_bad++; $display("FAIL rst_vid got=%b want=000", {vid_de, vid_hs, vid_vs}); end
    n_cmp++; if (vid_data !== 24'h000000) begin n_bad++; $display("FAIL rst_vid_data got=%h want=000000", vid_data); end
    n_cmp++; if ({p_vid_hs, p_vid_vs} !== 2'b11) begin n_bad++; $display("FAIL rst_pol_idle got=%b want=11", {p_vid_hs, p_vid_vs}); end
    rst_n = 1'b1;
    repeat (3) step();
    n_cmp++; if ({frame_busy, de_out, vid_de} !== 3'b000) begin n_bad++; $display("FAIL idle_after_rst got=%b want=000", {frame_busy, de_out, vid_de}); end
    n_cmp++; if ({p_vid_hs, p_vid_vs} !== 2'b11) begin n_bad++; $display("FAIL idle_pol got=%b want=11", {p_vid_hs, p_vid_vs}); end
  endtask

  task automatic test_single_trigger();
    play(110, -1, -1);
    n_cmp++; if (r_f_err != 0) begin n_bad++; $display("FAIL single_fetch_pattern errs=%0d want=0", r_f_err); end
    n_cmp++; if (r_busy_hi != 98) begin n_bad++; $display("FAIL single_busy_cycles got=%0d want=98", r_busy_hi); end
    n_cmp++; if (r_de_rises != 4) begin n_bad++; $display("FAIL single_de_bursts got=%0d want=4", r_de_rises); end
    n_cmp++; if (r_hs_rises != 7) begin n_bad++; $display("FAIL single_hs_pulses got=%0d want=7", r_hs_rises); end
    n_cmp++; if (r_vs_hi != 14) begin n_bad++; $display("FAIL single_vs_cycles got=%0d want=14", r_vs_hi); end
    n_cmp++; if (frame_busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end got=%b want=0", frame_busy); end
  endtask

  task automatic test_alignment();
    play(110, -1, -1);
    n_cmp++; if (r_v_err != 0) begin n_bad++; $display("FAIL align_vid errs=%0d want=0", r_v_err); end
    n_cmp++; if ({vid_de, vid_data} !== 25'h0) begin n_bad++; $display("FAIL align_idle got=%b/%h want=0/000000", vid_de, vid_data); end
  endtask

  task automatic test_polarity();
    play(110, -1, -1);
    n_cmp++; if (r_p_err != 0) begin n_bad++; $display("FAIL pol_low_active errs=%0d want=0", r_p_err); end
    n_cmp++; if ({p_vid_hs, p_vid_vs} !== 2'b11) begin n_bad++; $display("FAIL pol_idle_end got=%b want=11", {p_vid_hs, p_vid_vs}); end
  endtask

  task automatic test_back_to_back();
    play(200, 30, FT - 1);
    n_cmp++; if (r_busy_hi != 2 * FT) begin n_bad++; $display("FAIL b2b_busy_cycles got=%0d want=%0d", r_busy_hi, 2 * FT); end
    n_cmp++; if (r_f_err != 0) begin n_bad++; $display("FAIL b2b_fetch_pattern errs=%0d want=0", r_f_err); end
    n_cmp++; if (r_fifth != FT + 1) begin n_bad++; $display("FAIL b2b_second_de_start got=%0d want=%0d", r_fifth, FT + 1); end
    n_cmp++; if (r_de_rises != 8) begin n_bad++; $display("FAIL b2b_de_bursts got=%0d want=8", r_de_rises); end
    n_cmp++; if (r_v_err != 0) begin n_bad++; $display("FAIL b2b_vid errs=%0d want=0", r_v_err); end
  endtask

  task automatic test_async_reset();
    int errs;
    frame_trig = 1'b1;
    step();
    frame_trig = 1'b0;
    repeat (20) step();
    n_cmp++; if ({de_out, vid_de, frame_busy} !== 3'b111) begin n_bad++; $display("FAIL arst_pre got=%b want=111", {de_out, vid_de, frame_busy}); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({frame_busy, de_out, vid_de} !== 3'b000) begin n_bad++; $display("FAIL arst_immediate got=%b want=000", {frame_busy, de_out, vid_de}); end
    n_cmp++; if ({vid_hs, p_vid_hs} !== 2'b01) begin n_bad++; $display("FAIL arst_hs got=%b want=01", {vid_hs, p_vid_hs}); end
    repeat (3) step();
    #2;
    rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if ({frame_busy, de_out, vid_de} !== 3'b000) errs++;
    end
    n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL arst_no_autostart errs=%0d want=0", errs); end
    play(110, -1, -1);
    n_cmp++; if (r_f_err != 0) begin n_bad++; $display("FAIL arst_restart_pattern errs=%0d want=0", r_f_err); end
    n_cmp++; if (r_busy_hi != FT) begin n_bad++; $display("FAIL arst_restart_busy got=%0d want=%0d", r_busy_hi, FT); end
  endtask

`ifdef FRAME_TIMING_GEN_STATUS_EN
  task automatic test_status();
    status_clr = 1'b1;
    step();
    status_clr = 1'b0;
    n_cmp++; if ({frame_cnt, trig_drop} !== 17'h0) begin n_bad++; $display("FAIL status_clr0 got=%0d/%b want=0/0", frame_cnt, trig_drop); end
    play(200, 30, FT - 1);
    play(110, -1, -1);
    n_cmp++; if (frame_cnt !== 16'd3) begin n_bad++; $display("FAIL status_frame_cnt got=%0d want=3", frame_cnt); end
    n_cmp++; if (trig_drop !== 1'b1) begin n_bad++; $display("FAIL status_trig_drop got=%b want=1", trig_drop); end
    n_cmp++; if ({p_frame_cnt, p_trig_drop} !== {16'd3, 1'b1}) begin n_bad++; $display("FAIL status_pol_inst got=%0d/%b want=3/1", p_frame_cnt, p_trig_drop); end
    status_clr = 1'b1;
    step();
    status_clr = 1'b0;
    n_cmp++; if ({frame_cnt, trig_drop} !== 17'h0) begin n_bad++; $display("FAIL status_clr1 got=%0d/%b want=0/0", frame_cnt, trig_drop); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_trigger();
    test_alignment();
    test_polarity();
    test_back_to_back();
    test_async_reset();
`ifdef FRAME_TIMING_GEN_STATUS_EN
    test_status();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_timing_gen.md
Name: frame_timing_gen

Overview:
- Video timing generator directly downstream of the pattern fetch stage.
- On `frame_trig`, runs one frame of raster timing and drives `frame_busy` back to the fetch stage.
- Drives internal active-high `h_sync_out`, `v_sync_out` and `de_out` to the fetch stage.
- Re-aligns the returned pixel stream with delayed syncs and drives the HDMI transmitter interface (`vid_*`).

Parameters:
- H_ACTIVE, 1920, active pixels per line
- H_FP, 88, horizontal front porch (cycles)
- H_SYNC, 44, horizontal sync width
- H_BP, 148, horizontal back porch
- V_ACTIVE, 1080, active lines per frame
- V_FP, 4, vertical front porch (lines)
- V_SYNC, 5, vertical sync width (lines)
- V_BP, 36, vertical back porch (lines)
- HS_POL, 1, vid_hs polarity (1 = active high)
- VS_POL, 1, vid_vs polarity (1 = active high)
- DATA_LAT, 1, cycles from de_out to matching pix_data_in (range 1..4)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_trig  in  1  single-cycle frame start request from fetch stage
- frame_busy  out  1  high while a frame is being generated
- h_sync_out  out  1  active-high hsync to fetch stage
- v_sync_out  out  1  active-high vsync to fetch stage
- de_out  out  1  data enable to fetch stage
- pix_data_in  in  24  pixel from fetch stage, valid DATA_LAT cycles after de_out
- vid_hs  out  1  hsync to transmitter, polarity HS_POL
- vid_vs  out  1  vsync to transmitter, polarity VS_POL
- vid_de  out  1  data enable to transmitter
- vid_data  out  24  RGB888 to transmitter

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - state = IDLE; h_cnt = v_cnt = 0; all delay lines = 0.
  - frame_busy, h_sync_out, v_sync_out, de_out, vid_de = 0; vid_data = 0.
  - vid_hs = ~HS_POL; vid_vs = ~VS_POL.
- Reset mid-frame: immediate return to the reset values; no frame completion.
- Totals and counter widths:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL is the vertical equivalent.
  - h_cnt width is $clog2(H_TOTAL); v_cnt width is $clog2(V_TOTAL).
- IDLE state:
  - Counters held at 0; fetch-side outputs held at 0.
  - When frame_trig = 1 at a clock edge: state becomes RUN, frame_busy = 1, h_cnt = v_cnt = 0.
- RUN state, counting:
  - h_cnt increments each cycle and wraps at H_TOTAL-1.
  - On wrap, v_cnt increments.
- RUN state, end of frame (last cycle is h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1):
  - If frame_trig = 1 in that cycle: counters wrap to 0, state stays RUN, frame_busy stays 1 (seamless back-to-back).
  - Otherwise: state becomes IDLE and frame_busy falls at the same edge.
- frame_trig in any other RUN cycle is ignored.
- Fetch-side decode (registered, 1 cycle after the counter value):
  - de_out = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - h_sync_out = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC
  - v_sync_out = V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC
  - Decode is gated by state == RUN.
- Latency:
  - frame_trig sampled at edge T means the first de_out = 1 is visible after edge T+1.
  - de_out is high for H_ACTIVE consecutive cycles per active line.
- Transmitter side:
  - de_out, h_sync_out and v_sync_out are delayed DATA_LAT cycles in a shift register.
  - One further register stage produces vid_de, vid_hs (XOR with ~HS_POL), vid_vs (XOR with ~VS_POL), and vid_data = delayed de ? pix_data_in : 24'h0.
  - Total latency from de_out to vid_de is DATA_LAT+1 cycles.
  - vid_data is forced to 0 outside active video.
- frame_busy is asserted throughout blanking of the final line, so the fetch stage's next trigger is not accepted early.

Optional Feature:
- Macro: FRAME_TIMING_GEN_STATUS_EN.
- When defined, adds three ports:
  - frame_cnt, out, 16: increments at each frame end, wraps at 16'hFFFF → 0.
  - trig_drop, out, 1: sticky; set when frame_trig arrives in RUN outside the last frame cycle.
  - status_clr, in, 1: clears trig_drop and frame_cnt; if status_clr and a new drop occur in the same cycle, trig_drop is set.
- When not defined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package video_timing_pkg:
  - 1080p60 timing constants.
  - Typedef for RGB888 pixel (24-bit).
  - Function computing total and sync-start values from porch parameters.
- One natural sub-module: vid_delay_line, a parameterised DATA_LAT-deep shift register for {de, hs, vs}.

Test Plan:
- Bench parameters: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, DATA_LAT=1.
- Single trigger: frame_trig pulse in IDLE → frame_busy high for exactly 14*7 = 98 cycles; 4 de_out bursts of 8 cycles; 7 h_sync_out pulses of 2 cycles; v_sync_out high for 14 cycles starting at line 5.
- Back-to-back: frame_trig in the last frame cycle → frame_busy never drops; second frame's de_out starts exactly 98 cycles after the first; frame_trig mid-frame has no effect.
- Alignment: pix_data_in = incrementing value on de_out delayed 1 → vid_data carries 0..7 on each active line with vid_de high, and 0 elsewhere.
- Polarity: HS_POL=0, VS_POL=0 → vid_hs/vid_vs idle high and pulse low; idle high also immediately after reset.
- Async reset mid-active-line: rst_n low between edges → frame_busy, de_out and vid_de are 0 immediately; after release, a frame starts only on a new frame_trig, beginning at h=0, v=0.
- STATUS_EN: 3 frames plus one mid-frame trigger → frame_cnt = 3, trig_drop = 1; status_clr pulse → both 0.
